// File: rtl/weight_buffer_loader_if.sv
// rtl/weight_buffer_loader_if.sv - command, DDR beat stream and buffer write port bundle
interface weight_buffer_loader_if #(
    parameter int ADDR_LEN     = 16,
    parameter int DDR_DATA_LEN = 256,
    parameter int BUFFER_NUM   = 32,
    parameter int LEN_W        = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_LEN-1:0]     cmd_base;
    logic [LEN_W-1:0]        cmd_rows;
    logic [DDR_DATA_LEN-1:0] ddr_data;
    logic                    ddr_valid;
    logic                    ddr_ready;
    logic [DDR_DATA_LEN-1:0] data_wr;
    logic [ADDR_LEN-1:0]     wr_addr;
    logic [BUFFER_NUM-1:0]   wr_en;

    // Command/DMA side and buffer observer
    modport master (
        output cmd_valid, cmd_base, cmd_rows, ddr_data, ddr_valid,
        input  cmd_ready, ddr_ready, data_wr, wr_addr, wr_en
    );

    // Loader side
    modport slave (
        input  cmd_valid, cmd_base, cmd_rows, ddr_data, ddr_valid,
        output cmd_ready, ddr_ready, data_wr, wr_addr, wr_en
    );
endinterface

// File: rtl/weight_buffer_loader.sv
// rtl/weight_buffer_loader.sv - DDR beat to weight buffer row loader; optional WBL_STALL_CNT_EN starvation counter
module weight_buffer_loader #(
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int BUFFER_NUM   = 32,
    parameter int LEN_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    weight_buffer_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            stall_cnt
);
    localparam int GROUP_NUM     = BUFFER_NUM * DATA_LEN / DDR_DATA_LEN;
    localparam int BANKS_PER_GRP = DDR_DATA_LEN / DATA_LEN;
    localparam int GRP_W         = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_LEN-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]        rows_q, rows_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [DDR_DATA_LEN-1:0] data_wr_q, data_wr_d;
    logic [ADDR_LEN-1:0]     wr_addr_q, wr_addr_d;
    logic [BUFFER_NUM-1:0]   wr_en_q, wr_en_d;
    logic                    beat;
    logic                    row_end;

    assign beat    = (state_q == LOAD) && bus.ddr_valid;
    assign row_end = (grp_q == GRP_W'(GROUP_NUM - 1));

    // Next-state, address/row/group counters and registered write port
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rows_d    = rows_q;
        grp_d     = grp_q;
        data_wr_d = data_wr_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_base;
                    rows_d  = bus.cmd_rows;
                    grp_d   = '0;
                    state_d = (bus.cmd_rows != '0) ? LOAD : FIN;
                end
            end
            LOAD: begin
                if (beat) begin
                    data_wr_d = bus.ddr_data;
                    wr_addr_d = addr_q;
                    for (int g = 0; g < GROUP_NUM; g++) begin
                        if (grp_q == GRP_W'(g)) begin
                            wr_en_d[g*BANKS_PER_GRP +: BANKS_PER_GRP] = '1;
                        end
                    end
                    if (row_end) begin
                        grp_d  = '0;
                        addr_d = addr_q + ADDR_LEN'(1);
                        rows_d = rows_q - LEN_W'(1);
                        if (rows_q == LEN_W'(1)) begin
                            state_d = FIN;
                        end
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rows_q    <= '0;
            grp_q     <= '0;
            data_wr_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rows_q    <= rows_d;
            grp_q     <= grp_d;
            data_wr_q <= data_wr_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.ddr_ready = (state_q == LOAD);
    assign bus.data_wr   = data_wr_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_en     = wr_en_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);

`ifdef WBL_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Count LOAD cycles starved of DDR data, saturating
    always_comb begin
        stall_d = stall_q;
        if ((state_q == LOAD) && !bus.ddr_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Starvation counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_weight_buffer_loader.sv
// tb/tb_weight_buffer_loader.sv - scoreboard bench for weight_buffer_loader
module tb_weight_buffer_loader;
    localparam int GROUPS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] stall_cnt;

    weight_buffer_loader_if #(.ADDR_LEN(16), .DDR_DATA_LEN(256), .BUFFER_NUM(32), .LEN_W(16)) wb_if ();

    weight_buffer_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (wb_if),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic [31:0]  wen;
        logic [255:0] data;
        bit           last;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   zero_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   stall_m = 0;
    bit   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected writes / zero-row completions whenever the DUT presents them
    always @(negedge clk) begin
        exp_t e;
        int   c;
        checks++;
        if (wb_if.cmd_ready && wb_if.ddr_ready) begin
            errors++;
            $display("FAIL ready_excl cyc=%0d cmd_ready and ddr_ready both high", cyc);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write cyc=%0d expected addr=%h wen=%h at cyc %0d", cyc, e.addr, e.wen, e.cyc);
        end
        if (wb_if.wr_en != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d addr=%h wen=%h", cyc, wb_if.wr_addr, wb_if.wr_en);
            end else begin
                e = exp_q.pop_front();
                if (wb_if.wr_addr !== e.addr || wb_if.wr_en !== e.wen || wb_if.data_wr !== e.data ||
                    done !== e.last || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write cyc=%0d got addr=%h wen=%h done=%0b want addr=%h wen=%h done=%0b cyc=%0d data_ok=%0b",
                             cyc, wb_if.wr_addr, wb_if.wr_en, done, e.addr, e.wen, e.last, e.cyc,
                             wb_if.data_wr === e.data);
                end
            end
        end else if (done) begin
            checks++;
            if (zero_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d got done=1 want no done", cyc);
            end else begin
                c = zero_q.pop_front();
                if (c != cyc || wb_if.ddr_ready) begin
                    errors++;
                    $display("FAIL zero_done cyc=%0d got cyc=%0d ddr_ready=%0b want cyc=%0d ddr_ready=0",
                             cyc, cyc, wb_if.ddr_ready, c);
                end
            end
        end
        if (prev_done) begin
            checks++;
            if (!wb_if.cmd_ready) begin
                errors++;
                $display("FAIL ready_after_done cyc=%0d got cmd_ready=0 want 1", cyc);
            end
        end
        prev_done = done;
    end

    function automatic logic [255:0] rand_beat();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic wait_cmd_ready();
        int t = 0;
        while (!wb_if.cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!wb_if.cmd_ready) check("cmd_ready_timeout", 64'(wb_if.cmd_ready), 64'd1);
    endtask

    task automatic check_stall();
`ifdef WBL_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`else
        check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    endtask

    // gap: 0 back-to-back, 1 toggled, 2 random. rst_at>0 asserts reset once that many beats were accepted.
    task automatic run_cmd(input logic [15:0] base, input int rows, input int gap,
                           input bit pulse_cmd, input int rst_at);
        int  total = rows * GROUPS;
        int  k = 0;
        int  t = 0;
        bit  tog = 1'b1;
        bit  v;
        wait_cmd_ready();
        wb_if.cmd_valid = 1'b1;
        wb_if.cmd_base  = base;
        wb_if.cmd_rows  = 16'(rows);
        wb_if.ddr_valid = 1'b1;
        wb_if.ddr_data  = rand_beat();
        if (rows == 0) zero_q.push_back(cyc + 1);
        @(negedge clk);
        wb_if.cmd_valid = 1'b0;
        while (k < total && t < 2000) begin
            if (rst_at > 0 && k == rst_at) begin
                rst_n = 1'b0;
                wb_if.ddr_valid = 1'b1;
                wb_if.ddr_data  = rand_beat();
                @(negedge clk);
                stall_m = 0;
                check("rst_wr_en", 64'(wb_if.wr_en), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_cmd_ready", 64'(wb_if.cmd_ready), 64'd1);
                check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
                rst_n = 1'b1;
                wb_if.ddr_valid = 1'b0;
                return;
            end
            case (gap)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            wb_if.ddr_valid = v;
            wb_if.ddr_data  = rand_beat();
            wb_if.cmd_valid = pulse_cmd && wb_if.ddr_ready && ($urandom_range(0, 1) == 1);
            wb_if.cmd_base  = 16'($urandom);
            wb_if.cmd_rows  = 16'($urandom_range(1, 4));
            if (wb_if.ddr_ready && !v) stall_m++;
            if (wb_if.ddr_ready && v) begin
                exp_q.push_back('{addr: base + 16'(k / GROUPS),
                                  wen:  32'hF << (4 * (k % GROUPS)),
                                  data: wb_if.ddr_data,
                                  last: (k == total - 1),
                                  cyc:  cyc + 1});
                k++;
            end
            @(negedge clk);
            t++;
        end
        wb_if.ddr_valid = 1'b0;
        wb_if.cmd_valid = 1'b0;
        if (k < total) check("beat_timeout", 64'(k), 64'(total));
        wait_cmd_ready();
        check_stall();
        check("queue_drained", 64'(exp_q.size() + zero_q.size()), 64'd0);
    endtask

    initial begin
        wb_if.cmd_valid = 1'b0;
        wb_if.cmd_base  = '0;
        wb_if.cmd_rows  = '0;
        wb_if.ddr_valid = 1'b0;
        wb_if.ddr_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(wb_if.cmd_ready), 64'd1);
        check("reset_ddr_ready", 64'(wb_if.ddr_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_wr_en", 64'(wb_if.wr_en), 64'd0);
        check("reset_wr_addr", 64'(wb_if.wr_addr), 64'd0);
        check("reset_data_wr", 64'(wb_if.data_wr[63:0]), 64'd0);
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(16'h0000, 1, 0, 1'b0, 0);
        run_cmd(16'h0010, 2, 1, 1'b0, 0);
        run_cmd(16'hFFFF, 2, 2, 1'b0, 0);
        run_cmd(16'h1234, 0, 0, 1'b0, 0);
        run_cmd(16'h0040, 3, 0, 1'b0, 5);
        run_cmd(16'h0100, 1, 0, 1'b0, 0);
        run_cmd(16'h0200, 2, 2, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            run_cmd(16'($urandom), $urandom_range(0, 3), 2, 1'b1, 0);
        end

        repeat (3) @(negedge clk);
        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        check("final_zero_empty", 64'(zero_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_buffer_loader.md
# weight_buffer_loader

Write-side front end of the weight buffer. Accepts a load command (buffer start address, row count) and moves 256-bit DDR beats through a valid/ready stream. Each beat is replayed onto the buffer write port as `data_wr`/`wr_addr`/`wr_en`. Sits between the DDR read DMA and the weight buffer; one buffer row (all `BUFFER_NUM` banks at one address) holds one 3x3 tap for the full 16x16 PE mesh.

## Interface
- `ADDR_LEN`, 16, buffer address width
- `DATA_LEN`, 64, bank word width
- `DDR_DATA_LEN`, 256, DDR beat width
- `BUFFER_NUM`, 32, number of banks
- `GROUP_NUM`, `BUFFER_NUM*DATA_LEN/DDR_DATA_LEN` (8), beats per row
- `BANKS_PER_GRP`, `DDR_DATA_LEN/DATA_LEN` (4), banks written per beat
- `LEN_W`, 16, row-count width

Ports:
- `clk` in 1: clock
- `rst_n` in 1: synchronous, active-low reset
- `cmd_valid` in 1: load command valid
- `cmd_ready` out 1: loader idle, command can be accepted
- `cmd_base` in `ADDR_LEN`: first buffer address
- `cmd_rows` in `LEN_W`: rows to write; 0 is legal
- `ddr_data` in `DDR_DATA_LEN`: DDR beat
- `ddr_valid` in 1: beat valid
- `ddr_ready` out 1: loader accepts beat
- `data_wr` out `DDR_DATA_LEN`: buffer write data, replicated per group by the buffer
- `wr_addr` out `ADDR_LEN`: buffer write address
- `wr_en` out `BUFFER_NUM`: per-bank write strobe
- `busy` out 1: command in progress
- `done` out 1: one-cycle completion pulse
- `stall_cnt` out 32: DDR starvation cycles; see Configuration

## Operation
- **FSM states:** IDLE, LOAD, FIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch base into the address register, latch rows, clear the group counter.
  - Next state: LOAD if rows≠0, else FIN.
- **LOAD**
  - `ddr_ready`=1, driven from the state register only.
  - A beat is accepted when `ddr_valid && ddr_ready`.
  - On each accepted beat, register:
    - `data_wr` ← `ddr_data`
    - `wr_addr` ← current address
    - `wr_en` ← `BANKS_PER_GRP` ones at bits [g*4 +: 4], where g is the group counter.
  - g increments after each beat. At g=`GROUP_NUM`-1, g wraps to 0, the address increments, and the remaining row count decrements.
  - When the last beat of the last row is accepted, the next state is FIN.
- **FIN**
  - Lasts one cycle with `done`=1, then returns to IDLE.
- **Arithmetic:**
  - The address wraps modulo 2^`ADDR_LEN`; 0xFFFF+1 → 0x0000, with no error.
  - Total beats = rows×`GROUP_NUM`.
- **Outputs:**
  - `busy` = state≠IDLE.
  - `cmd_ready` and `ddr_ready` are never high together.
- **Reset (synchronous, any state):** state=IDLE, every output and counter cleared.
  - `wr_en`=0, `data_wr`=0, `wr_addr`=0, `done`=0, `busy`=0, `stall_cnt`=0.
  - A partially loaded command is abandoned. A beat accepted in the reset cycle is not written.

## Timing
- **Write latency:** beat accepted in cycle t → `wr_en`/`wr_addr`/`data_wr` valid in cycle t+1 only. `wr_en`=0 in every other cycle.
- **Throughput:** one beat per cycle; one row in `GROUP_NUM` cycles with no gaps.
- **Completion:**
  - `done` is asserted in the same cycle as the final `wr_en` strobe.
  - `cmd_ready` rises in the cycle after `done`.
  - The next command's first write can occur 3 cycles after `done` at the earliest: accept, first beat, write.
- **rows=0:** command accepted at t → `done` at t+1, no `wr_en`, `cmd_ready` at t+2.
- **Gaps:** `ddr_valid` gaps are legal at any beat; the counters hold during gaps.
- **Ignored inputs:** `cmd_valid` while busy is ignored (not latched). `ddr_valid` outside LOAD is ignored.

## Configuration
- **`WBL_STALL_CNT_EN` defined:** `stall_cnt` increments once per cycle in LOAD with `ddr_valid`=0. It saturates at 2^32-1, clears on reset only, and is readable at any time.
- **`WBL_STALL_CNT_EN` undefined:** no counter logic; `stall_cnt` is tied to 0.

## Test plan
- **Basic load:** base=0x0000, rows=1, 8 back-to-back beats D0..D7.
  - 8 consecutive writes at `wr_addr`=0.
  - `wr_en` = 0x0000000F, 0x000000F0, …, 0xF0000000, with `data_wr`=Dk.
  - `done` coincides with the 8th write; `cmd_ready` is high the next cycle.
- **Backpressure/gaps:** base=0x0010, rows=2, `ddr_valid` toggled 1/0.
  - 16 writes, addr 0x0010 ×8 then 0x0011 ×8, each one cycle after its accepted beat.
  - With the macro defined, `stall_cnt` equals the number of low-valid LOAD cycles.
- **Address wrap:** base=0xFFFF, rows=2 → 8 writes at 0xFFFF, then 8 at 0x0000, then `done`.
- **Zero rows:** rows=0 → `done` exactly one cycle after accept, `ddr_ready` never high, `wr_en` never set.
- **Reset mid-load:** rows=3, `rst_n` low after 5 beats.
  - Next cycle: `wr_en`=0, `busy`=0, `cmd_ready`=1, `stall_cnt`=0.
  - A new command (base 0x0100, rows 1) then completes normally from group 0.
- **Ignored command:** `cmd_valid` pulsed with different `cmd_base` during LOAD → no effect; the original address sequence completes.
